// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder; the only arithmetic cell used by the serial adder.
module full_adder (
    input  logic c_in,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are consumed LSB-first through a single full_adder,
// with the running carry held in a flip-flop between bit-steps.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | waiting for start; sum/c_out hold the last result
//   S_RUN  | one bit-step per clock, WIDTH steps in total
//   S_DONE | done pulse cycle; start here is accepted back-to-back
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_next;

    full_adder u_fa (
        .c_in  (carry),
        .a     (sa[0]),
        .b     (sb[0]),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    // New bit enters at the MSB; after WIDTH steps bit 0 of the operands has reached bit 0 here.
    assign sum_next = {fa_sum, sum_sr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            sa     <= '0;
            sb     <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            c_out  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= c_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sum_sr <= sum_next[WIDTH-1:1];
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    carry  <= fa_cout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= sum_next;
                        c_out <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): directed vectors plus a randomised sweep.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;

    typedef struct {
        logic [7:0] s;
        logic       co;
        int         cyc;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_err     = 0;
    int   edge_cnt  = 0;
    int   done_seen = 0;
    int   op_id     = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) begin
                n_err++;
                $display("FAIL busy_done_overlap: busy=%b done=%b, required not both 1", busy, done);
            end
            if (done) begin
                exp_t e;
                done_seen++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: got sum=%h c_out=%b, required no done", sum, c_out);
                end else begin
                    e = exp_q.pop_front();
                    if (sum !== e.s || c_out !== e.co) begin
                        n_err++;
                        $display("FAIL op%0d_result: got sum=%h c_out=%b, required sum=%h c_out=%b",
                                 e.id, sum, c_out, e.s, e.co);
                    end
                    n_checks++;
                    if (edge_cnt != e.cyc) begin
                        n_err++;
                        $display("FAIL op%0d_latency: done after edge %0d, required edge %0d",
                                 e.id, edge_cnt, e.cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Drives one accepted start and records the expected result and done edge.
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         input logic [7:0] es, input logic eco);
        @(negedge clk);
        a = ta; b = tb_v; c_in = tc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back('{s: es, co: eco, cyc: edge_cnt + 8, id: op_id});
        op_id++;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL done_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",  busy,  0);
        check("reset_done",  done,  0);
        check("reset_sum",   sum,   0);
        check("reset_c_out", c_out, 0);
        rst = 1'b0;

        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("busy_while_run", busy, 1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("hold_sum",   sum,   8'h00);
        check("hold_c_out", c_out, 1);
        check("idle_busy",  busy,  0);
        check("idle_done",  done,  0);

        issue(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1);
        wait_idle();
        issue(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        wait_idle();

        // A start during busy must be ignored.
        issue(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (12) @(negedge clk);

        // Back-to-back: start stays high; the second op is taken on the done cycle.
        @(negedge clk);
        a = 8'h11; b = 8'h22; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{s: 8'h33, co: 1'b0, cyc: edge_cnt + 8, id: op_id});
        op_id++;
        a = 8'h80; b = 8'h80; c_in = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        exp_q.push_back('{s: 8'h00, co: 1'b1, cyc: edge_cnt + 8, id: op_id});
        op_id++;
        start = 1'b0;
        wait_idle();

        // Reset in the middle of a run discards the partial result.
        issue(8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy",  busy,  0);
        check("midrst_done",  done,  0);
        check("midrst_sum",   sum,   0);
        check("midrst_c_out", c_out, 0);
        d0 = done_seen;
        repeat (15) @(negedge clk);
        check("midrst_no_done", done_seen, d0);
        issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        wait_idle();

        for (int i = 0; i < 500; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            logic [8:0] r;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            r  = 9'(ra) + 9'(rb) + 9'(rc);
            issue(ra, rb, rc, r[7:0], r[8]);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
